// File: rtl/command_buffer_control_pkg.sv
// Shared types and defaults for the PSL command buffer: FSM state, command/response
// lines and the status word published back to the command producers.
package command_buffer_control_pkg;

   localparam int CB_DEPTH         = 16;
   localparam int CB_ALFULL_MARGIN = 4;

   typedef enum logic {
      CB_DISABLED = 1'b0,
      CB_ACTIVE   = 1'b1
   } cb_state;

   typedef enum logic [3:0] {
      INVALID    = 4'h0,
      READ_CL_NA = 4'h1,
      READ_CL_S  = 4'h2,
      WRITE_NA   = 4'h3,
      WRITE_MS   = 4'h4,
      TOUCH_I    = 4'h5
   } command_type;

   typedef enum logic [7:0] {
      DONE   = 8'h00,
      AERROR = 8'h01,
      DERROR = 8'h03,
      FAILED = 8'h07,
      PAGED  = 8'h0a
   } response_type;

   typedef struct packed {
      logic        valid;
      command_type command;
      logic [7:0]  cu_id;
      logic [11:0] size;
      logic [63:0] address;
   } CommandBufferLine;

   typedef struct packed {
      logic         valid;
      logic [7:0]   tag;
      response_type response;
   } ResponseBufferLine;

   typedef struct packed {
      logic valid;
      logic empty;
      logic full;
      logic alfull;
   } BufferStatus;

endpackage

// File: rtl/command_buffer_control_fifo.sv
// Synchronous FIFO of command lines; flags decode the registered count, so they move on
// the same edge as the occupancy. A pop in the same cycle makes room for a push when full.
module fifo_commandbufferline
   import command_buffer_control_pkg::*;
#(
   parameter int DEPTH         = CB_DEPTH,
   parameter int ALFULL_MARGIN = CB_ALFULL_MARGIN
) (
   input  logic                    clock,
   input  logic                    rstn,
   input  logic                    push,
   input  CommandBufferLine        push_data,
   input  logic                    pop,
   output CommandBufferLine        head,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    empty,
   output logic                    full,
   output logic                    alfull
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LEVEL   = (AW+1)'(DEPTH);
   localparam logic [AW:0] ALFULL_LEVEL = (AW+1)'(DEPTH - ALFULL_MARGIN);

   CommandBufferLine mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

   assign head   = mem[rd_ptr];
   assign empty  = (count == '0);
   assign full   = (count == FULL_LEVEL);
   assign alfull = (count >= ALFULL_LEVEL);

endmodule

// File: rtl/command_buffer_control.sv
// Credit-gated command queue to the PSL: one registered issue per cycle (earliest the cycle
// after a push), gated by command credits; producers are throttled only via alfull/full.
module command_buffer_control
   import command_buffer_control_pkg::*;
#(
   parameter int DEPTH         = CB_DEPTH,
   parameter int ALFULL_MARGIN = CB_ALFULL_MARGIN,
   parameter int TAG_WIDTH     = 8,
   parameter int CREDIT_WIDTH  = 8
) (
   input  logic                    clock,
   input  logic                    rstn,
   input  logic                    enabled_in,
   input  logic [CREDIT_WIDTH-1:0] croom_in,
   input  CommandBufferLine        command_in,
   input  ResponseBufferLine       response_in,
   output BufferStatus             command_buffer_status,
   output CommandBufferLine        command_out,
   output logic [TAG_WIDTH-1:0]    command_tag_out,
   output logic                    overflow_out
);

   logic                    enabled;
   cb_state                 state;
   cb_state                 state_next;
   logic                    load_credits;
   logic                    clear_credits;
   logic                    issue;
   logic [CREDIT_WIDTH-1:0] credits;
   logic [CREDIT_WIDTH-1:0] credit_max;
   logic [TAG_WIDTH-1:0]    tag;
   logic                    fifo_empty;
   logic                    fifo_full;
   logic                    fifo_alfull;
   logic [$clog2(DEPTH):0]  fifo_count;
   CommandBufferLine        fifo_head;
   CommandBufferLine        issued_line;
   logic                    response_unused;

   // Only the valid bit of a response matters here; tag/code are consumed upstream.
   assign response_unused = ^{response_in.tag, response_in.response};

   fifo_commandbufferline #(
      .DEPTH         (DEPTH),
      .ALFULL_MARGIN (ALFULL_MARGIN)
   ) u_fifo (
      .clock     (clock),
      .rstn      (rstn),
      .push      (command_in.valid),
      .push_data (command_in),
      .pop       (issue),
      .head      (fifo_head),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .alfull    (fifo_alfull)
   );

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         enabled <= 1'b0;
         state   <= CB_DISABLED;
      end else begin
         enabled <= enabled_in;
         state   <= state_next;
      end
   end

   always_comb begin
      state_next    = state;
      load_credits  = 1'b0;
      clear_credits = 1'b0;
      issue         = 1'b0;
      case (state)
         CB_DISABLED: begin
            if (enabled) begin
               state_next   = CB_ACTIVE;
               load_credits = 1'b1;
            end
         end
         CB_ACTIVE: begin
            issue = (fifo_count != '0) && (credits != '0);
            if (!enabled) begin
               state_next    = CB_DISABLED;
               clear_credits = 1'b1;
            end
         end
         default: state_next = CB_DISABLED;
      endcase
   end

   // croom is only trusted at enable time; returns can never exceed that room.
   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         credits    <= '0;
         credit_max <= '0;
      end else if (load_credits) begin
         credits    <= croom_in;
         credit_max <= croom_in;
      end else if (clear_credits) begin
         credits <= '0;
      end else if (state == CB_ACTIVE) begin
         if (issue && !response_in.valid)
            credits <= credits - 1'b1;
         else if (!issue && response_in.valid && (credits < credit_max))
            credits <= credits + 1'b1;
      end
   end

   always_comb begin
      issued_line       = fifo_head;
      issued_line.valid = 1'b1;
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         command_out     <= '0;
         command_tag_out <= '0;
         tag             <= '0;
      end else if (issue) begin
         command_out     <= issued_line;
         command_tag_out <= tag;
         tag             <= tag + 1'b1;
      end else begin
         command_out.valid <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn)
         overflow_out <= 1'b0;
      else if (command_in.valid && fifo_full && !issue)
         overflow_out <= 1'b1;
   end

   always_comb begin
      command_buffer_status.valid  = !fifo_empty;
      command_buffer_status.empty  = fifo_empty;
      command_buffer_status.full   = fifo_full;
      command_buffer_status.alfull = fifo_alfull;
   end

endmodule

// File: tb/tb_command_buffer_control.sv
// Directed bench for command_buffer_control: queue-based reference model checked every cycle,
// plus hand-computed expectations for issue tags, timing, fill levels and reset.
module tb_command_buffer_control;
   import command_buffer_control_pkg::*;

   localparam int DEPTH = 16;

   logic              clock;
   logic              rstn;
   logic              enabled_in;
   logic [7:0]        croom_in;
   CommandBufferLine  command_in;
   ResponseBufferLine response_in;
   BufferStatus       command_buffer_status;
   CommandBufferLine  command_out;
   logic [7:0]        command_tag_out;
   logic              overflow_out;

   command_buffer_control #(
      .DEPTH         (16),
      .ALFULL_MARGIN (4),
      .TAG_WIDTH     (8),
      .CREDIT_WIDTH  (8)
   ) dut (
      .clock                 (clock),
      .rstn                  (rstn),
      .enabled_in            (enabled_in),
      .croom_in              (croom_in),
      .command_in            (command_in),
      .response_in           (response_in),
      .command_buffer_status (command_buffer_status),
      .command_out           (command_out),
      .command_tag_out       (command_tag_out),
      .overflow_out          (overflow_out)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int resp_cyc;
   int log_tag[$];
   int log_cyc[$];
   int log_cu[$];

   // reference model state
   CommandBufferLine exp_q[$];
   CommandBufferLine exp_out;
   logic             exp_out_vld;
   logic [7:0]       exp_out_tag;
   logic [7:0]       exp_tag;
   logic             exp_over;
   logic             exp_en;
   logic             exp_active;
   int               exp_credits;
   int               exp_max;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_out     = '0;
      exp_out_vld = 1'b0;
      exp_out_tag = '0;
      exp_tag     = '0;
      exp_over    = 1'b0;
      exp_en      = 1'b0;
      exp_active  = 1'b0;
      exp_credits = 0;
      exp_max     = 0;
   endtask

   task automatic model_step();
      bit issue;
      bit was_full;
      issue    = exp_active && (exp_q.size() > 0) && (exp_credits > 0);
      was_full = (exp_q.size() == DEPTH);
      if (issue) begin
         exp_out     = exp_q.pop_front();
         exp_out_tag = exp_tag;
         exp_tag     = exp_tag + 8'd1;
      end
      exp_out_vld = issue;
      if (command_in.valid) begin
         if (!was_full || issue) exp_q.push_back(command_in);
         else exp_over = 1'b1;
      end
      if (!exp_active && exp_en) begin
         exp_credits = int'(croom_in);
         exp_max     = int'(croom_in);
      end else if (exp_active && !exp_en) begin
         exp_credits = 0;
      end else if (exp_active) begin
         if (issue && !response_in.valid) exp_credits = exp_credits - 1;
         else if (!issue && response_in.valid && exp_credits < exp_max) exp_credits = exp_credits + 1;
      end
      exp_active = exp_en;
      exp_en     = enabled_in;
   endtask

   always @(posedge clock or negedge rstn) begin
      if (!rstn) model_reset();
      else model_step();
   end

   always @(negedge clock) begin
      CommandBufferLine e;
      BufferStatus      es;
      e        = exp_out;
      e.valid  = exp_out_vld;
      es.valid  = (exp_q.size() != 0);
      es.empty  = (exp_q.size() == 0);
      es.full   = (exp_q.size() == DEPTH);
      es.alfull = (exp_q.size() >= DEPTH - 4);
      check("model_command_out", 128'(command_out), 128'(e));
      check("model_tag", 128'(command_tag_out), 128'(exp_out_tag));
      check("model_status", 128'(command_buffer_status), 128'(es));
      check("model_overflow", 128'(overflow_out), 128'(exp_over));
      if (command_out.valid === 1'b1) begin
         log_tag.push_back(int'(command_tag_out));
         log_cyc.push_back(cyc);
         log_cu.push_back(int'(command_out.cu_id));
      end
   end

   function automatic CommandBufferLine mk(input int i);
      CommandBufferLine l;
      l.valid   = 1'b1;
      l.command = (i % 2 == 1) ? READ_CL_NA : WRITE_NA;
      l.cu_id   = 8'(i);
      l.size    = 12'd128;
      l.address = 64'h1000_0000 + 64'(i) * 64'd128;
      return l;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input int i);
      command_in = mk(i);
      tick();
      command_in = '0;
   endtask

   task automatic clear_log();
      log_tag.delete();
      log_cyc.delete();
      log_cu.delete();
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      #1;
      rstn = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   initial begin
      rstn        = 1'b1;
      enabled_in  = 1'b0;
      croom_in    = '0;
      command_in  = '0;
      response_in = '0;
      #1 rstn = 1'b0;
      tick();
      tick();
      check("rst_out_valid", 128'(command_out.valid), 128'd0);
      check("rst_out_line", 128'(command_out), 128'd0);
      check("rst_status", 128'(command_buffer_status), 128'b0100);
      check("rst_overflow", 128'(overflow_out), 128'd0);
      check("rst_tag", 128'(command_tag_out), 128'd0);
      rstn = 1'b1;
      tick();

      // credits=2, three pushes: two back-to-back issues, third after one response
      croom_in   = 8'd2;
      enabled_in = 1'b1;
      tick();
      clear_log();
      push(1);
      push(2);
      push(3);
      repeat (4) tick();
      check("t1_two_issued", 128'(log_tag.size()), 128'd2);
      check("t1_tag0", 128'(log_tag[0]), 128'd0);
      check("t1_tag1", 128'(log_tag[1]), 128'd1);
      check("t1_consecutive", 128'(log_cyc[1]), 128'(log_cyc[0] + 1));
      response_in.valid = 1'b1;
      resp_cyc = cyc;
      tick();
      response_in = '0;
      repeat (3) tick();
      check("t1_three_issued", 128'(log_tag.size()), 128'd3);
      check("t1_tag2", 128'(log_tag[2]), 128'd2);
      check("t1_cu2", 128'(log_cu[2]), 128'd3);
      check("t1_third_timing", 128'(log_cyc[2]), 128'(resp_cyc + 2));

      // fill with zero credits, then overflow
      enabled_in = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 11; i++) push(100 + i);
      check("t2_alfull_at_11", 128'(command_buffer_status.alfull), 128'd0);
      push(111);
      check("t2_alfull_at_12", 128'(command_buffer_status.alfull), 128'd1);
      check("t2_not_full_at_12", 128'(command_buffer_status.full), 128'd0);
      for (int i = 12; i < 16; i++) push(100 + i);
      check("t2_full_at_16", 128'(command_buffer_status.full), 128'd1);
      check("t2_no_overflow_yet", 128'(overflow_out), 128'd0);
      push(116);
      check("t2_overflow", 128'(overflow_out), 128'd1);
      check("t2_still_full", 128'(command_buffer_status.full), 128'd1);

      // full + push + issue; issue + response
      do_reset();
      for (int i = 0; i < 16; i++) push(i);
      croom_in   = 8'd3;
      enabled_in = 1'b1;
      tick();
      tick();
      clear_log();
      command_in = mk(200);
      tick();
      command_in = '0;
      check("t3_full_kept", 128'(command_buffer_status.full), 128'd1);
      check("t3_no_overflow", 128'(overflow_out), 128'd0);
      check("t3_issued", 128'(command_out.valid), 128'd1);
      response_in.valid = 1'b1;
      tick();
      response_in = '0;
      repeat (6) tick();
      check("t3_issue_count", 128'(log_tag.size()), 128'd4);
      check("t3_fifo_order", 128'(log_cu[0]), 128'd0);

      // tag wrap through 256 with a response every cycle
      enabled_in = 1'b0;
      croom_in   = 8'd8;
      do_reset();
      enabled_in = 1'b1;
      tick();
      tick();
      clear_log();
      for (int i = 0; i < 262; i++) begin
         command_in        = mk(i);
         response_in.valid = 1'b1;
         tick();
      end
      command_in  = '0;
      response_in = '0;
      repeat (12) tick();
      check("t4_issue_count", 128'(log_tag.size()), 128'd262);
      check("t4_tag255", 128'(log_tag[255]), 128'd255);
      check("t4_tag_wrap0", 128'(log_tag[256]), 128'd0);
      check("t4_tag_wrap1", 128'(log_tag[257]), 128'd1);
      check("t4_order", 128'(log_cu[257]), 128'd1);

      // credit saturation at croom
      do_reset();
      croom_in = 8'd4;
      tick();
      tick();
      clear_log();
      for (int i = 0; i < 3; i++) begin
         response_in.valid = 1'b1;
         tick();
      end
      response_in = '0;
      for (int i = 0; i < 5; i++) push(60 + i);
      repeat (10) tick();
      check("t5_issue_count", 128'(log_tag.size()), 128'd4);
      check("t5_one_left", 128'(command_buffer_status.empty), 128'd0);

      // asynchronous reset with queued entries and a live issue
      enabled_in = 1'b0;
      do_reset();
      tick();
      for (int i = 0; i < 7; i++) push(70 + i);
      croom_in   = 8'd2;
      enabled_in = 1'b1;
      repeat (4) tick();
      check("t6_live_issue", 128'(command_out.valid), 128'd1);
      check("t6_five_queued", 128'(dut.u_fifo.count), 128'd5);
      rstn = 1'b0;
      #1;
      check("t6_rst_out_valid", 128'(command_out.valid), 128'd0);
      check("t6_rst_empty", 128'(command_buffer_status.empty), 128'd1);
      check("t6_rst_tag", 128'(command_tag_out), 128'd0);
      #1 rstn = 1'b1;
      clear_log();
      push(50);
      repeat (5) tick();
      check("t6_reissue_count", 128'(log_tag.size()), 128'd1);
      check("t6_reissue_tag", 128'(log_tag[0]), 128'd0);
      check("t6_reissue_cu", 128'(log_cu[0]), 128'd50);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
